// File: rtl/alu_control_fsm_if.sv
// Bundle for the instruction handshake, the ALU operand/result path, the register-file
// write-back strobes and the debug read port of alu_control_fsm.
interface alu_control_fsm_if #(
    parameter int DW = 32
);
    logic          instr_valid;
    logic [31:0]   instr;
    logic          instr_ready;
    logic [2:0]    AluOp;
    logic [DW-1:0] Ope1;
    logic [DW-1:0] Ope2;
    logic [DW-1:0] Resultado;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          done;
    logic          illegal;
    logic [4:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    // The master is the instruction source plus the ALU.
    modport master (
        output instr_valid, instr, Resultado, dbg_addr,
        input  instr_ready, AluOp, Ope1, Ope2, wr_en, wr_addr, wr_data,
               done, illegal, dbg_data
    );

    modport slave (
        input  instr_valid, instr, Resultado, dbg_addr,
        output instr_ready, AluOp, Ope1, Ope2, wr_en, wr_addr, wr_data,
               done, illegal, dbg_data
    );
endinterface

// File: rtl/alu_control_fsm.sv
// Four-state sequencer (IDLE/DECODE/EXEC/WB): decodes one MIPS R/I instruction,
// drives the external ALU, captures its result and writes it back to a 32x32 register file.
module alu_control_fsm #(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_control_fsm_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    state_t        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [2:0]    aluop_q, aluop_d;
    logic [DW-1:0] ope1_q, ope1_d;
    logic [DW-1:0] ope2_q, ope2_d;
    logic [DW-1:0] result_q, result_d;
    logic [4:0]    dest_q, dest_d;
    logic          illegal_q, illegal_d;
    logic [DW-1:0] regs_q [32];
    logic [DW-1:0] regs_d [32];

    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [DW-1:0] rs_val, rt_val;
    logic          dec_legal;
    logic [2:0]    dec_aluop;
    logic [DW-1:0] dec_ope1, dec_ope2;
    logic [4:0]    dec_dest;
    logic          wb_we;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign imm    = instr_q[15:0];
    assign funct  = instr_q[5:0];

    // R0 never gets written, so its storage reads as zero without a special case.
    assign rs_val = regs_q[rs];
    assign rt_val = regs_q[rt];

    always_comb begin
        dec_legal = 1'b1;
        dec_aluop = 3'b000;
        dec_ope1  = rs_val;
        dec_ope2  = rt_val;
        dec_dest  = rd;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100100: dec_aluop = 3'b000;
                    6'b100101: dec_aluop = 3'b001;
                    6'b100000: dec_aluop = 3'b010;
                    6'b100010: dec_aluop = 3'b110;
                    6'b101011: begin
                        // ALU computes Ope1 > Ope2, so swapping gives rs < rt.
                        dec_aluop = 3'b111;
                        dec_ope1  = rt_val;
                        dec_ope2  = rs_val;
                    end
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b001000: begin
                dec_aluop = 3'b010;
                dec_ope2  = {{(DW-16){imm[15]}}, imm};
                dec_dest  = rt;
            end
            6'b001100: begin
                dec_aluop = 3'b000;
                dec_ope2  = {{(DW-16){1'b0}}, imm};
                dec_dest  = rt;
            end
            6'b001101: begin
                dec_aluop = 3'b001;
                dec_ope2  = {{(DW-16){1'b0}}, imm};
                dec_dest  = rt;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.instr_valid) state_d = S_DECODE;
            S_DECODE: state_d = dec_legal ? S_EXEC : S_IDLE;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.instr_ready = (state_q == S_IDLE);
        bus.done        = (state_q == S_WB);
        wb_we           = (state_q == S_WB) && (dest_q != 5'd0);
        bus.wr_en       = wb_we;
    end

    always_comb begin
        instr_d   = instr_q;
        aluop_d   = aluop_q;
        ope1_d    = ope1_q;
        ope2_d    = ope2_q;
        dest_d    = dest_q;
        result_d  = result_q;
        illegal_d = 1'b0;
        if (state_q == S_IDLE && bus.instr_valid) instr_d = bus.instr;
        if (state_q == S_DECODE) begin
            if (dec_legal) begin
                aluop_d = dec_aluop;
                ope1_d  = dec_ope1;
                ope2_d  = dec_ope2;
                dest_d  = dec_dest;
            end else begin
                illegal_d = 1'b1;
            end
        end
        if (state_q == S_EXEC) result_d = bus.Resultado;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q   <= '0;
            aluop_q   <= '0;
            ope1_q    <= '0;
            ope2_q    <= '0;
            dest_q    <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            aluop_q   <= aluop_d;
            ope1_q    <= ope1_d;
            ope2_q    <= ope2_d;
            dest_q    <= dest_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file: cleared as a whole on reset, one write port from WB.
    for (genvar gi = 0; gi < 32; gi++) begin : g_regs
        assign regs_d[gi] = (wb_we && dest_q == 5'(gi)) ? result_q : regs_q[gi];
        always_ff @(posedge clk) begin
            if (!rst_n) regs_q[gi] <= '0;
            else        regs_q[gi] <= regs_d[gi];
        end
    end

    assign bus.AluOp    = aluop_q;
    assign bus.Ope1     = ope1_q;
    assign bus.Ope2     = ope2_q;
    assign bus.wr_addr  = dest_q;
    assign bus.wr_data  = result_q;
    assign bus.illegal  = illegal_q;
    assign bus.dbg_data = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_control_fsm.sv
// Bench for alu_control_fsm: behavioural ALU, table of instructions with hand-derived
// expectations pushed to a scoreboard on acceptance and checked when done/illegal fires.
module tb_alu_control_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_control_fsm_if #(.DW(32)) bus ();

    alu_control_fsm #(.DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_comb begin
        case (bus.AluOp)
            3'b000:  bus.Resultado = bus.Ope1 & bus.Ope2;
            3'b001:  bus.Resultado = bus.Ope1 | bus.Ope2;
            3'b010:  bus.Resultado = bus.Ope1 + bus.Ope2;
            3'b110:  bus.Resultado = bus.Ope1 - bus.Ope2;
            3'b111:  bus.Resultado = {31'd0, bus.Ope1 > bus.Ope2};
            default: bus.Resultado = 32'd0;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        logic [2:0]  aluop;
        logic [31:0] ope1;
        logic [31:0] ope2;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } sb_t;

    localparam int N = 14;
    vec_t        vecs [N];
    logic [31:0] exp_regs [12];
    sb_t         sbq [$];
    sb_t         e;
    int          total = 0;
    int          bad = 0;
    int          retired = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic ill, input logic [2:0] op,
                                input logic [31:0] o1, input logic [31:0] o2, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd);
        vec_t v;
        v.instr = ins; v.ill = ill; v.aluop = op; v.ope1 = o1; v.ope2 = o2;
        v.we = we; v.waddr = wa; v.wdata = wd;
        return v;
    endfunction

    // Scoreboard side: every done/illegal pulse retires the oldest accepted instruction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done || bus.illegal) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_retire", {30'd0, bus.done, bus.illegal}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    retired++;
                    chk("illegal", {31'd0, bus.illegal}, {31'd0, e.v.ill});
                    chk("done", {31'd0, bus.done}, {31'd0, !e.v.ill});
                    chk("latency", cyc - e.acc, e.v.ill ? 32'd1 : 32'd2);
                    chk("aluop", {29'd0, bus.AluOp}, {29'd0, e.v.aluop});
                    chk("ope1", bus.Ope1, e.v.ope1);
                    chk("ope2", bus.Ope2, e.v.ope2);
                    chk("wr_en", {31'd0, bus.wr_en}, {31'd0, e.v.we});
                    chk("ready_at_retire", {31'd0, bus.instr_ready}, {31'd0, e.v.ill});
                    if (!e.v.ill) begin
                        chk("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e.v.waddr});
                        chk("wr_data", bus.wr_data, e.v.wdata);
                    end
                    $display("txn instr=%h ill=%0d op=%b ope1=%h ope2=%h we=%0d addr=%0d data=%h",
                             e.v.instr, bus.illegal, bus.AluOp, bus.Ope1, bus.Ope2,
                             bus.wr_en, bus.wr_addr, bus.wr_data);
                end
            end else if (bus.wr_en) begin
                chk("stray_wr_en", {31'd0, bus.wr_en}, 32'd0);
            end
        end
    end

    task automatic send(input vec_t v, input bit hold, input bit track, output int acc);
        int n;
        bus.instr_valid = 1'b1;
        bus.instr       = v.instr;
        n = 0;
        while (!bus.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) chk("accept_timeout", {31'd0, bus.instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (track) sbq.push_back('{v: v, acc: cyc});
        if (!hold) bus.instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        chk("drain", sbq.size(), 32'd0);
    endtask

    task automatic check_regs(input string name, input bit zeros);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.dbg_addr = 5'(i);
            #1;
            chk(name, bus.dbg_data, zeros ? 32'd0 : exp_regs[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        vec_t v7;

        vecs[0]  = mk(32'h20010005, 0, 3'b010, 32'h0,        32'h5,        1, 5'd1,  32'h5);
        vecs[1]  = mk(32'h2002FFFD, 0, 3'b010, 32'h0,        32'hFFFFFFFD, 1, 5'd2,  32'hFFFFFFFD);
        vecs[2]  = mk(32'h00221822, 0, 3'b110, 32'h5,        32'hFFFFFFFD, 1, 5'd3,  32'h8);
        vecs[3]  = mk(32'h0022202B, 0, 3'b111, 32'hFFFFFFFD, 32'h5,        1, 5'd4,  32'h1);
        vecs[4]  = mk(32'h3405F0F0, 0, 3'b001, 32'h0,        32'h0000F0F0, 1, 5'd5,  32'h0000F0F0);
        vecs[5]  = mk(32'h30A60FF0, 0, 3'b000, 32'h0000F0F0, 32'h00000FF0, 1, 5'd6,  32'h000000F0);
        vecs[6]  = mk(32'h20000007, 0, 3'b010, 32'h0,        32'h7,        0, 5'd0,  32'h7);
        vecs[7]  = mk(32'hFC000000, 1, 3'b010, 32'h0,        32'h7,        0, 5'd0,  32'h0);
        vecs[8]  = mk(32'h00000001, 1, 3'b010, 32'h0,        32'h7,        0, 5'd0,  32'h0);
        vecs[9]  = mk(32'h00643820, 0, 3'b010, 32'h8,        32'h1,        1, 5'd7,  32'h9);
        vecs[10] = mk(32'h00454025, 0, 3'b001, 32'hFFFFFFFD, 32'h0000F0F0, 1, 5'd8,  32'hFFFFFFFD);
        vecs[11] = mk(32'h20490003, 0, 3'b010, 32'hFFFFFFFD, 32'h3,        1, 5'd9,  32'h0);
        vecs[12] = mk(32'h0041502B, 0, 3'b111, 32'h5,        32'hFFFFFFFD, 1, 5'd10, 32'h0);
        vecs[13] = mk(32'h00215960, 0, 3'b010, 32'h5,        32'h5,        1, 5'd11, 32'hA);
        exp_regs = '{32'h0, 32'h5, 32'hFFFFFFFD, 32'h8, 32'h1, 32'h0000F0F0,
                     32'h000000F0, 32'h9, 32'hFFFFFFFD, 32'h0, 32'h0, 32'hA};
        v7 = mk(32'h20070009, 0, 3'b010, 32'h0, 32'h9, 1, 5'd7, 32'h9);

        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.dbg_addr    = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   {31'd0, bus.instr_ready}, 32'd1);
        chk("rst_done",    {31'd0, bus.done}, 32'd0);
        chk("rst_aluop",   {29'd0, bus.AluOp}, 32'd0);
        chk("rst_ope1",    bus.Ope1, 32'd0);
        chk("rst_ope2",    bus.Ope2, 32'd0);
        chk("rst_wr_en",   {31'd0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        rst_n = 1'b1;

        // Single instruction with an idle gap, then read-back through the debug port.
        send(vecs[0], 0, 1, acc);
        drain();
        bus.dbg_addr = 5'd1;
        #1;
        chk("dbg_r1", bus.dbg_data, 32'h5);

        // Remaining table back-to-back with instr_valid held high.
        prev = 0;
        for (int i = 1; i < N; i++) begin
            send(vecs[i], (i != N - 1), 1, acc);
            if (i > 1) chk("accept_spacing", acc - prev, vecs[i-1].ill ? 32'd2 : 32'd4);
            prev = acc;
        end
        drain();
        chk("retired_count", retired, N);
        check_regs("reg_after_table", 0);

        // Reset asserted for one cycle while ADDI r7,r0,9 is in EXEC.
        send(v7, 0, 0, acc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_ready",   {31'd0, bus.instr_ready}, 32'd1);
        chk("midrst_wr_data", bus.wr_data, 32'd0);
        chk("midrst_aluop",   {29'd0, bus.AluOp}, 32'd0);
        chk("midrst_ope2",    bus.Ope2, 32'd0);
        repeat (6) @(negedge clk);
        check_regs("reg_after_reset", 1);

        // Recovery after reset.
        send(vecs[0], 0, 1, acc);
        drain();
        bus.dbg_addr = 5'd1;
        #1;
        chk("dbg_r1_recover", bus.dbg_data, 32'h5);
        chk("retired_total", retired, N + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_control_fsm.md
# alu_control_fsm

Multi-cycle instruction sequencer that drives the combinational ALU. It accepts one 32-bit MIPS-format instruction per handshake and decodes it into `AluOp` and operands. It holds the 32×32 register file, captures the ALU `Resultado`, and writes back. It sits between the instruction source (fetch unit or testbench) and the ALU, and owns the ALU's input side.

## Interface
- `DW`, default 32: data width. It must equal the ALU operand width, and only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_valid` in 1: an instruction is offered on `instr`.
- `instr` in 32: instruction word.
- `instr_ready` out 1: the sequencer can accept an instruction.
- `AluOp` out 3: ALU operation select (000 AND, 001 OR, 010 ADD, 110 SUB, 111 unsigned greater-than).
- `Ope1` out DW: ALU operand 1.
- `Ope2` out DW: ALU operand 2.
- `Resultado` in DW: combinational ALU result.
- `wr_en` out 1: register-file write strobe, which is observable.
- `wr_addr` out 5: write destination.
- `wr_data` out DW: write data.
- `done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse when an instruction is rejected.
- `dbg_addr` in 5: register-file debug read address.
- `dbg_data` out DW: combinational read of `regs[dbg_addr]`.

## Operation
- **Supported opcodes and funct codes**
  - R-type, opcode 000000, by funct:
    - 100100 AND → 000
    - 100101 OR → 001
    - 100000 ADD → 010
    - 100010 SUB → 110
    - 101011 SLTU → 111, with operands swapped.
  - R-type operands: `Ope1`=rs and `Ope2`=rt. For SLTU, `Ope1`=rt and `Ope2`=rs, so the result is 1 iff rs < rt unsigned. The destination is rd.
  - I-type:
    - ADDI 001000 → 010, with imm sign-extended.
    - ANDI 001100 → 000, with imm zero-extended.
    - ORI 001101 → 001, with imm zero-extended.
  - I-type operands: `Ope1`=rs and `Ope2`=extended imm. The destination is rt.
- **Illegal instructions**: any other opcode, or any other funct when opcode is 000000, is illegal. Shamt is ignored.
- **Register file**: 32×32, and R0 reads as 0. A write whose destination is 0 is suppressed (`wr_en` stays 0), but `done` still pulses.
- **Arithmetic**: all arithmetic is modulo 2^32. There are no overflow traps.
- **FSM states**: IDLE, DECODE, EXEC, WB.
  - **IDLE**: `instr_ready`=1. When `instr_valid`=1, latch `instr` and go to DECODE.
  - **DECODE**: read rs and rt, then register `AluOp`, `Ope1`, `Ope2` and the destination.
    - If the instruction is illegal: pulse `illegal`, leave `AluOp`/`Ope1`/`Ope2` unchanged, and return to IDLE.
    - Otherwise go to EXEC.
  - **EXEC**: register `Resultado` into the result register and go to WB.
  - **WB**: drive `wr_en` (destination≠0), `wr_addr` and `wr_data` equal to the result register. Pulse `done`, write the register file on this edge, and go to IDLE.
- **Read-after-write**: a value written in WB is visible to the next instruction's DECODE and to `dbg_data` from the following cycle.
- **Reset**: `rst_n`=0 at any edge, including mid-instruction, does all of the following:
  - forces IDLE;
  - clears all 32 registers and the result register;
  - abandons any in-flight instruction with no write, `done` or `illegal`.

## Timing
- **Reset values**: `instr_ready`=1 and `done`=0. Every other output resets to 0: `AluOp`=000, `Ope1`=0, `Ope2`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `illegal`=0.
- **Handshake**: a transfer occurs on an edge where `instr_valid`=1 and `instr_ready`=1.
  - `instr_ready`=1 only in IDLE.
  - The source must hold `instr` stable while `instr_valid`=1 and `instr_ready`=0.
- **Legal instruction latency**: accept at edge T0. `AluOp`, `Ope1` and `Ope2` are valid after T1, and the result is captured at T2. `done`/`wr_en` are high in the cycle after T2, and the register is written at T3. `instr_ready` returns high after T3, giving a throughput of 1 instruction per 4 cycles.
- **Illegal instruction**: `illegal` is high in the cycle after T1, and `instr_ready`=1 again after T1.
- **Output hold**: `AluOp`, `Ope1`, `Ope2` are registered and held between instructions. `wr_en`, `done`, `illegal` are single-cycle pulses.
- **ALU path**: the ALU path must meet one cycle from `Ope1`/`Ope2` to the result register.

## Test plan
- Reset, then ADDI r1,r0,5 (0x20010005) → `AluOp`=010, `Ope1`=0, `Ope2`=5. Then `done` and `wr_en` pulse 3 cycles after acceptance with `wr_addr`=1 and `wr_data`=5, and `dbg_data`(1)=5.
- ADDI r2,r0,-3 (0x2002FFFD) → r2=0xFFFFFFFD. Then SUB r3,r1,r2 (0x00221822) → r3=8. Then SLTU r4,r1,r2 (0x0022202B) → `Ope1`=0xFFFFFFFD, `Ope2`=5, r4=1.
- ORI r5,r0,0xF0F0 then ANDI r6,r5,0x0FF0 → r5=0x0000F0F0 and r6=0x000000F0. ADDI r0,r0,7 → `done` pulses, `wr_en`=0, and r0 still reads 0.
- Illegal opcode 0xFC000000, then illegal funct 0x00000001 → each gives an `illegal` pulse 2 cycles after acceptance, with no `wr_en` and no `done`. `instr_ready` is back high the following cycle, and `AluOp`/`Ope1`/`Ope2` are unchanged.
- Hold `instr_valid` high continuously with back-to-back instructions → exactly one acceptance per 4 cycles. `instr_ready` is 0 during DECODE, EXEC and WB, and no instruction is dropped or duplicated.
- Assert `rst_n`=0 for one cycle during EXEC of ADDI r7,r0,9 → no write, r7=0, and all previously written registers read 0. `instr_ready`=1 on the next cycle.
